// File: rtl/audio_mixer_serial.sv
// -----------------------------------------------------------------------------
// audio_mixer_serial
//
// Time-multiplexed audio mixer and gain stage for the sigma-delta DAC.
// On each sample strobe the channel samples, per-channel volumes and the mute
// flag are snapshotted. The scaled samples are then accumulated serially
// through a single multiplier, one channel per cycle. The sum is scaled,
// saturated and converted to excess-2^(OW-1) (offset binary) form. The result
// is held on dout until the next mix completes.
//
// Parameters:
//   CH  number of input channels (>= 1)
//   IW  width of each signed channel sample
//   OW  output word width (OW <= IW, OW >= 2)
//
// Ports:
//   CLK         system clock, rising edge
//   RESET       asynchronous active-high reset
//   sample_stb  one-cycle pulse requesting a new mix
//   ch_in       packed signed samples, channel k at [k*IW +: IW]
//   vol         packed unsigned volumes, channel k at [k*8 +: 8] (128 = unity)
//   mute        global mute, captured with the snapshot
//   dout        offset-binary sample to the DAC, held between updates
//   dout_valid  one-cycle pulse when dout updates
//   busy        high while a mix is in progress
//   overrun     sticky: a strobe arrived while busy
// -----------------------------------------------------------------------------
module audio_mixer_serial #(
    parameter int CH = 4,
    parameter int IW = 16,
    parameter int OW = 16
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               sample_stb,
    input  logic [CH*IW-1:0]   ch_in,
    input  logic [CH*8-1:0]    vol,
    input  logic               mute,
    output logic [OW-1:0]      dout,
    output logic               dout_valid,
    output logic               busy,
    output logic               overrun
);

    localparam int CW = (CH > 1) ? $clog2(CH) : 1;
    localparam int PW = IW + 9;                  // sample x {0,vol} product width
    localparam int AW = IW + 9 + $clog2(CH);     // cannot overflow across CH terms
    localparam int SH = 7 + IW - OW;             // unity-gain shift plus LSB drop

    localparam logic [CW-1:0]        LAST_IDX = CW'(CH - 1);
    localparam logic [OW-1:0]        MIDSCALE = {1'b1, {(OW-1){1'b0}}};
    localparam logic signed [AW-1:0] MAX_VAL  = $signed({{(AW-OW+1){1'b0}}, {(OW-1){1'b1}}});
    localparam logic signed [AW-1:0] MIN_VAL  = $signed({{(AW-OW+1){1'b1}}, {(OW-1){1'b0}}});

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t                 state_reg, state_next;
    logic [CH*IW-1:0]       snap_ch_reg;
    logic [CH*8-1:0]        snap_vol_reg;
    logic                   snap_mute_reg;
    logic                   snap_load;
    logic signed [AW-1:0]   acc_reg, acc_next;
    logic [CW-1:0]          idx_reg, idx_next;
    logic [OW-1:0]          dout_reg, dout_next;
    logic                   dout_valid_reg, dout_valid_next;
    logic                   busy_reg, busy_next;
    logic                   overrun_reg, overrun_next;

    // Unpack the snapshot so the MAC can select a channel by index.
    logic signed [IW-1:0]   snap_ch_arr  [CH];
    logic [7:0]             snap_vol_arr [CH];

    generate
        for (genvar gi = 0; gi < CH; gi++) begin : g_unpack
            assign snap_ch_arr[gi]  = $signed(snap_ch_reg[gi*IW +: IW]);
            assign snap_vol_arr[gi] = snap_vol_reg[gi*8 +: 8];
        end
    endgenerate

    logic signed [IW-1:0]   ch_sel;
    logic signed [8:0]      vol_sel;
    logic signed [PW-1:0]   prod;
    logic signed [AW-1:0]   acc_sum;
    logic signed [AW-1:0]   shifted;
    logic [OW-1:0]          sat;

    always_comb begin
        ch_sel  = snap_ch_arr[idx_reg];
        // Zero-extend the volume so the signed multiply treats it as unsigned.
        vol_sel = $signed({1'b0, snap_vol_arr[idx_reg]});
        prod    = ch_sel * vol_sel;
        acc_sum = acc_reg + AW'(prod);

        // Arithmetic shift floors toward -inf, matching the gain definition.
        shifted = acc_reg >>> SH;
        if (shifted > MAX_VAL) begin
            sat = {1'b0, {(OW-1){1'b1}}};
        end else if (shifted < MIN_VAL) begin
            sat = {1'b1, {(OW-1){1'b0}}};
        end else begin
            sat = shifted[OW-1:0];
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_next      = state_reg;
        acc_next        = acc_reg;
        idx_next        = idx_reg;
        dout_next       = dout_reg;
        dout_valid_next = 1'b0;
        busy_next       = busy_reg;
        overrun_next    = overrun_reg;
        snap_load       = 1'b0;

        case (state_reg)
            IDLE: begin
                if (sample_stb) begin
                    snap_load  = 1'b1;
                    acc_next   = '0;
                    idx_next   = '0;
                    busy_next  = 1'b1;
                    state_next = MAC;
                end
            end
            MAC: begin
                if (sample_stb) begin
                    overrun_next = 1'b1;
                end
                acc_next = acc_sum;
                idx_next = idx_reg + CW'(1);
                if (idx_reg == LAST_IDX) begin
                    state_next = OUT;
                end
            end
            OUT: begin
                if (sample_stb) begin
                    overrun_next = 1'b1;
                end
                // Offset binary: invert the two's-complement sign bit.
                dout_next       = snap_mute_reg ? MIDSCALE : {~sat[OW-1], sat[OW-2:0]};
                dout_valid_next = 1'b1;
                busy_next       = 1'b0;
                state_next      = IDLE;
            end
            default: begin
                state_next = IDLE;
                busy_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_reg      <= IDLE;
            acc_reg        <= '0;
            idx_reg        <= '0;
            dout_reg       <= MIDSCALE;
            dout_valid_reg <= 1'b0;
            busy_reg       <= 1'b0;
            overrun_reg    <= 1'b0;
            snap_ch_reg    <= '0;
            snap_vol_reg   <= '0;
            snap_mute_reg  <= 1'b0;
        end else begin
            state_reg      <= state_next;
            acc_reg        <= acc_next;
            idx_reg        <= idx_next;
            dout_reg       <= dout_next;
            dout_valid_reg <= dout_valid_next;
            busy_reg       <= busy_next;
            overrun_reg    <= overrun_next;
            if (snap_load) begin
                snap_ch_reg   <= ch_in;
                snap_vol_reg  <= vol;
                snap_mute_reg <= mute;
            end
        end
    end

    assign dout       = dout_reg;
    assign dout_valid = dout_valid_reg;
    assign busy       = busy_reg;
    assign overrun    = overrun_reg;

endmodule

// File: tb/tb_audio_mixer_serial.sv
// -----------------------------------------------------------------------------
// tb_audio_mixer_serial
//
// Self-checking bench for audio_mixer_serial (CH=4, IW=OW=16). A table of
// directed mixes with hand-computed results is applied in a loop, followed by
// hand-written sequences for strobe spacing, overrun/snapshot behaviour and
// asynchronous reset in the middle of a mix.
// -----------------------------------------------------------------------------
module tb_audio_mixer_serial;

    localparam int CH = 4;
    localparam int IW = 16;
    localparam int OW = 16;

    logic               clk;
    logic               rst;
    logic               sample_stb;
    logic [CH*IW-1:0]   ch_in;
    logic [CH*8-1:0]    vol;
    logic               mute;
    logic [OW-1:0]      dout;
    logic               dout_valid;
    logic               busy;
    logic               overrun;

    int n_checks = 0;
    int n_fail   = 0;

    audio_mixer_serial #(.CH(CH), .IW(IW), .OW(OW)) dut (
        .CLK        (clk),
        .RESET      (rst),
        .sample_stb (sample_stb),
        .ch_in      (ch_in),
        .vol        (vol),
        .mute       (mute),
        .dout       (dout),
        .dout_valid (dout_valid),
        .busy       (busy),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string             name;
        logic [CH*IW-1:0]  ch;
        logic [CH*8-1:0]   vl;
        logic              mt;
        logic [OW-1:0]     exp_dout;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, got);
        end
    endtask

    // Launch one mix from a negedge and wait (bounded) for the result.
    task automatic run_mix(input string name, input logic [CH*IW-1:0] c,
                           input logic [CH*8-1:0] v, input logic m,
                           input logic [OW-1:0] exp_dout);
        int n;
        int busy_cnt;
        logic [OW-1:0] held;
        @(negedge clk);
        ch_in = c; vol = v; mute = m; sample_stb = 1'b1;
        @(negedge clk);            // strobe sampled on the edge just passed
        sample_stb = 1'b0;
        n = 0;
        busy_cnt = 0;
        while (!dout_valid && n < 20) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            n++;
        end
        check({name, " latency"}, n, CH + 1);
        check({name, " busy_cycles"}, busy_cnt, CH + 1);
        check({name, " dout"}, dout, exp_dout);
        held = dout;
        @(negedge clk);
        check({name, " valid_pulse_end"}, dout_valid, 1'b0);
        check({name, " dout_hold"}, dout, held);
    endtask

    initial begin
        int pulses;
        logic [OW-1:0] got0;
        logic [OW-1:0] got1;

        vecs[0] = '{"unity_ch0",   {16'h0000, 16'h0000, 16'h0000, 16'h1000},
                                   {8'd0, 8'd0, 8'd0, 8'd128}, 1'b0, 16'h9000};
        vecs[1] = '{"pos_sat",     {16'h0000, 16'h0000, 16'h7000, 16'h7000},
                                   {8'd0, 8'd0, 8'd255, 8'd255}, 1'b0, 16'hFFFF};
        vecs[2] = '{"neg_sat",     {16'h0000, 16'h0000, 16'h8000, 16'h8000},
                                   {8'd0, 8'd0, 8'd255, 8'd255}, 1'b0, 16'h0000};
        vecs[3] = '{"floor_neg",   {16'h0000, 16'h0000, 16'h0000, 16'hFFFF},
                                   {8'd0, 8'd0, 8'd0, 8'd64}, 1'b0, 16'h7FFF};
        vecs[4] = '{"mute",        {16'h0000, 16'h0000, 16'h0000, 16'hFFFF},
                                   {8'd0, 8'd0, 8'd0, 8'd64}, 1'b1, 16'h8000};
        // 4096 + 4096 - 4096 + 510 = 4606 = 0x11FE -> 0x91FE
        vecs[5] = '{"four_ch_mix", {16'h0100, 16'hF000, 16'h2000, 16'h1000},
                                   {8'd255, 8'd128, 8'd64, 8'd128}, 1'b0, 16'h91FE};

        sample_stb = 1'b0;
        ch_in = '0;
        vol = '0;
        mute = 1'b0;
        rst = 1'b1;
        #1;
        check("reset dout", dout, 16'h8000);
        check("reset dout_valid", dout_valid, 1'b0);
        check("reset busy", busy, 1'b0);
        check("reset overrun", overrun, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_mix(vecs[i].name, vecs[i].ch, vecs[i].vl, vecs[i].mt, vecs[i].exp_dout);
        end
        check("no overrun after table", overrun, 1'b0);

        // Strobes exactly CH+2 cycles apart are both accepted.
        pulses = 0; got0 = '0; got1 = '0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (dout_valid) begin
                if (pulses == 0) got0 = dout; else got1 = dout;
                pulses++;
            end
            sample_stb = (c == 0 || c == 6);
            if (c == 0) begin ch_in = {48'h0, 16'h1000}; vol = {24'h0, 8'd128}; mute = 1'b0; end
            if (c == 6) ch_in = {48'h0, 16'h0800};
        end
        check("spacing pulses", pulses, 2);
        check("spacing dout0", got0, 16'h9000);
        check("spacing dout1", got1, 16'h8800);
        check("spacing overrun", overrun, 1'b0);

        // Strobe during MAC is ignored; snapshot protects the mix in progress.
        pulses = 0; got0 = '0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (dout_valid) begin
                got0 = dout;
                pulses++;
            end
            sample_stb = (c == 0 || c == 2);
            if (c == 0) begin ch_in = {48'h0, 16'h1000}; vol = {24'h0, 8'd128}; end
            if (c == 2) ch_in = {48'h0, 16'h3000};
        end
        check("overrun pulses", pulses, 1);
        check("overrun dout", got0, 16'h9000);
        check("overrun set", overrun, 1'b1);
        repeat (5) @(negedge clk);
        check("overrun sticky", overrun, 1'b1);

        // Asynchronous reset two cycles into a mix.
        pulses = 0;
        @(negedge clk);
        ch_in = {48'h0, 16'h1000}; vol = {24'h0, 8'd128}; sample_stb = 1'b1;
        @(negedge clk);
        sample_stb = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midmac reset dout", dout, 16'h8000);
        check("midmac reset busy", busy, 1'b0);
        check("midmac reset overrun", overrun, 1'b0);
        check("midmac reset valid", dout_valid, 1'b0);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (c == 2) rst = 1'b0;
            if (dout_valid) pulses++;
        end
        check("midmac no pulse", pulses, 0);
        check("midmac dout idle", dout, 16'h8000);
        run_mix("after_reset", {48'h0, 16'h1000}, {24'h0, 8'd128}, 1'b0, 16'h9000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Absolute time bound so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, limit 200000");
        $fatal(1, "timeout");
    end

endmodule
